// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_arb_pkg (package)
//  Description : Shared types and constants for the packet-atomic AXI-Stream
//                arbiter and its rotating-priority picker.
//                  cfg_e       - converter split mode carried on m_cfg
//                  arb_state_e - arbiter lock state
//                  PKT_CNT_W   - width of each optional per-source counter
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

    typedef enum logic [1:0] {
        CFG_LSB = 2'd0,
        CFG_MSB = 2'd1,
        CFG_LE  = 2'd2,
        CFG_BE  = 2'd3
    } cfg_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int PKT_CNT_W = 16;

endpackage : axis_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating-priority picker. Searches req starting
//                at ptr+1 and wrapping modulo N_SRC; the first set request wins.
//                Intended for reuse by any scheduler needing round-robin order.
//  Ports       : req [N_SRC]  request vector
//                ptr [ID_W]   index of the previous winner (lowest priority)
//                any          at least one request is set
//                idx [ID_W]   winning index (0 when any=0)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter  int N_SRC = 4,
    localparam int ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    // Walk the offsets from farthest to nearest so the nearest candidate
    // after ptr is the last to overwrite idx, giving it highest priority.
    always_comb begin
        logic [ID_W-1:0] w_pos;
        w_pos = '0;
        any   = |req;
        idx   = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            w_pos = ID_W'((int'(ptr) + k) % N_SRC);
            if (req[w_pos]) begin
                idx = w_pos;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkt_arbiter
//  Description : Packet-atomic round-robin arbiter in front of a shared
//                AXI-Stream width-converter/CDC input. One IDLE cycle picks a
//                winner and latches its converter mode; LOCK then passes the
//                granted source straight through until its last-beat handshake.
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                src_cfg      [N_SRC*2]   per-source converter mode
//                s_axis_*                 N_SRC source streams (data/valid/last/ready)
//                m_axis_*                 stream towards the converter
//                m_cfg        [2]         mode latched at grant, stable per packet
//                grant_id     [ID_W]      current/last granted source
//                busy                     a packet is locked
//                pkt_cnt      [N_SRC*16]  per-source packet counters (optional)
//  Options     : AXIS_ARB_STATS_EN - adds pkt_cnt and its counters
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int N_SRC = 4,
    parameter  int WIDTH = 64,
    localparam int ID_W  = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC*2-1:0]     src_cfg,
    input  logic [N_SRC*WIDTH-1:0] s_axis_data,
    input  logic [N_SRC-1:0]       s_axis_valid,
    input  logic [N_SRC-1:0]       s_axis_last,
    output logic [N_SRC-1:0]       s_axis_ready,
    output logic [WIDTH-1:0]       m_axis_data,
    output logic                   m_axis_valid,
    output logic                   m_axis_last,
    input  logic                   m_axis_ready,
    output logic [1:0]             m_cfg,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy
`ifdef AXIS_ARB_STATS_EN
    ,
    output logic [N_SRC*PKT_CNT_W-1:0] pkt_cnt
`endif
);

    localparam logic [0:0]      c_st_idle  = ARB_IDLE;
    localparam logic [0:0]      c_st_lock  = ARB_LOCK;
    // Previous winner at reset is the top index, so source 0 wins first.
    localparam logic [ID_W-1:0] c_ptr_init = ID_W'(N_SRC - 1);

    logic [0:0]      r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_grant;
    logic [1:0]      r_cfg;

    logic            w_any;
    logic [ID_W-1:0] w_win;
    logic            w_lock;
    logic            w_done;

    logic [WIDTH-1:0] w_src_data [N_SRC];
    logic [1:0]       w_src_cfg  [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign w_src_data[i] = s_axis_data[i*WIDTH +: WIDTH];
        assign w_src_cfg[i]  = src_cfg[i*2 +: 2];
    end

    rr_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .req (s_axis_valid),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_win)
    );

    assign w_lock   = (r_state == c_st_lock);
    assign busy     = w_lock;
    assign grant_id = r_grant;
    assign m_cfg    = r_cfg;

    // Pass-through while locked. m_axis_valid depends only on registered
    // state and source valid, never on m_axis_ready.
    always_comb begin
        m_axis_data  = '0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        s_axis_ready = '0;
        if (w_lock) begin
            m_axis_data           = w_src_data[r_grant];
            m_axis_valid          = s_axis_valid[r_grant];
            m_axis_last           = s_axis_last[r_grant];
            s_axis_ready[r_grant] = m_axis_ready;
        end
    end

    assign w_done = w_lock & m_axis_valid & m_axis_ready & m_axis_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_ptr   <= c_ptr_init;
            r_grant <= '0;
            r_cfg   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_state <= c_st_lock;
                        r_grant <= w_win;
                        r_cfg   <= w_src_cfg[w_win];
                    end
                end
                c_st_lock: begin
                    // Leaving through IDLE forces the one-cycle gap even
                    // when the same source has another packet waiting.
                    if (w_done) begin
                        r_state <= c_st_idle;
                        r_ptr   <= r_grant;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef AXIS_ARB_STATS_EN
    for (genvar i = 0; i < N_SRC; i++) begin : g_stats
        logic [PKT_CNT_W-1:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_done && (r_grant == ID_W'(i))) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
        assign pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] = r_cnt;
    end
`endif

endmodule : axis_pkt_arbiter
`default_nettype wire
